// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// Issues one operation to the single-precision FPU datapath and returns the result.
// A command is taken over a valid/ready channel, and its operands and opcode are
// registered. They are held stable on the FPU inputs for FPU_LAT cycles. The
// combinational FPU result is then captured. Result, tag and error flag go back on
// a valid/ready response channel. An illegal opcode skips the FPU and responds
// with rsp_err set and a zero result. op_count counts completed legal operations
// and saturates at 0xFFFF.

module fpu_issue_ctrl #(
    parameter int unsigned FPU_LAT = 2,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [6:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      fpu_data1,
    output logic [31:0]      fpu_data2,
    output logic [6:0]       fpu_opcode,
    input  logic [31:0]      fpu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [15:0]      op_count
);

    localparam logic [6:0]  OP_ADD      = 7'd1;
    localparam logic [6:0]  OP_SUB      = 7'd2;
    localparam logic [6:0]  OP_MUL      = 7'd3;
    localparam logic [3:0]  SETTLE_INIT = 4'(FPU_LAT - 1);
    localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Only add, sub and mul are routed to the FPU; every other code is rejected.
    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_ADD:  legal = 1'b1;
            OP_SUB:  legal = 1'b1;
            OP_MUL:  legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic               cmd_ready_r;
    logic               rsp_valid_r;
    logic [3:0]         settle_cnt_r;
    logic [31:0]        fpu_data1_r;
    logic [31:0]        fpu_data2_r;
    logic [6:0]         fpu_opcode_r;
    logic [31:0]        rsp_result_r;
    logic [TAG_W-1:0]   rsp_tag_r;
    logic               rsp_err_r;
    logic [15:0]        op_count_r;
    logic               accept_s;
    logic               accept_legal_s;
    logic               capture_s;
    logic               rsp_done_s;

    // Next-state decode and handshake strobes derived from the current state.
    always_comb begin
        state_nx_s     = state_r;
        accept_s       = 1'b0;
        accept_legal_s = 1'b0;
        capture_s      = 1'b0;
        rsp_done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    if (is_legal_op(cmd_op)) begin
                        accept_legal_s = 1'b1;
                        state_nx_s     = ST_WAIT;
                    end else begin
                        state_nx_s     = ST_RESP;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (settle_cnt_r == 4'd0) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_done_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cmd_ready_r <= (state_nx_s == ST_IDLE);
            rsp_valid_r <= (state_nx_s == ST_RESP);
        end
    end

    // Operand/opcode holding registers; only a legal accept changes what the FPU sees.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_data1_r  <= 32'd0;
            fpu_data2_r  <= 32'd0;
            fpu_opcode_r <= 7'd0;
        end else if (accept_legal_s) begin
            fpu_data1_r  <= cmd_a;
            fpu_data2_r  <= cmd_b;
            fpu_opcode_r <= cmd_op;
        end
    end

    // Settle counter: loaded on a legal accept, counts down through WAIT to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt_r <= 4'd0;
        end else if (accept_legal_s) begin
            settle_cnt_r <= SETTLE_INIT;
        end else if ((state_r == ST_WAIT) && (settle_cnt_r != 4'd0)) begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
        end
    end

    // Response payload: tag on any accept, result/error on capture or illegal accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_r <= 32'd0;
            rsp_tag_r    <= '0;
            rsp_err_r    <= 1'b0;
        end else if (accept_s) begin
            rsp_tag_r <= cmd_tag;
            if (!accept_legal_s) begin
                rsp_result_r <= 32'd0;
                rsp_err_r    <= 1'b1;
            end
        end else if (capture_s) begin
            rsp_result_r <= fpu_result;
            rsp_err_r    <= 1'b0;
        end
    end

    // Completed-operation counter; counts legal responses and saturates at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r <= 16'd0;
        end else if (rsp_done_s && !rsp_err_r && (op_count_r != COUNT_MAX)) begin
            op_count_r <= op_count_r + 16'd1;
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign fpu_data1  = fpu_data1_r;
    assign fpu_data2  = fpu_data2_r;
    assign fpu_opcode = fpu_opcode_r;
    assign rsp_result = rsp_result_r;
    assign rsp_tag    = rsp_tag_r;
    assign rsp_err    = rsp_err_r;
    assign op_count   = op_count_r;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl
// Directed bench for fpu_issue_ctrl. A table-driven FPU stand-in returns the
// hand-computed IEEE-754 results for the test vectors.

module tb_fpu_issue_ctrl;

    localparam int unsigned FPU_LAT = 2;
    localparam int unsigned TAG_W   = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [6:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      fpu_data1;
    logic [31:0]      fpu_data2;
    logic [6:0]       fpu_opcode;
    logic [31:0]      fpu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [15:0]      op_count;

    int total = 0;
    int bad   = 0;

    fpu_issue_ctrl #(
        .FPU_LAT (FPU_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_tag    (cmd_tag),
        .fpu_data1  (fpu_data1),
        .fpu_data2  (fpu_data2),
        .fpu_opcode (fpu_opcode),
        .fpu_result (fpu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU stand-in: 1.5+2.25=3.75, 3.75-1.5=2.25, 2.0*3.0=6.0; anything else is a xor pattern.
    always_comb begin
        fpu_result = fpu_data1 ^ fpu_data2;
        if ((fpu_opcode == 7'd1) && (fpu_data1 == 32'h3FC00000) && (fpu_data2 == 32'h40100000)) begin
            fpu_result = 32'h40700000;
        end else if ((fpu_opcode == 7'd2) && (fpu_data1 == 32'h40700000) && (fpu_data2 == 32'h3FC00000)) begin
            fpu_result = 32'h40100000;
        end else if ((fpu_opcode == 7'd3) && (fpu_data1 == 32'h40000000) && (fpu_data2 == 32'h40400000)) begin
            fpu_result = 32'h40C00000;
        end else begin
            fpu_result = fpu_data1 ^ fpu_data2;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for cmd_ready, presents one command, returns edges until rsp_valid.
    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, output int lat);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a     = 32'hA5A5A5A5;
        cmd_b     = 32'h5A5A5A5A;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Completes the pending response with a one-cycle rsp_ready pulse.
    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Global watchdog so a stuck DUT can never hang the run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic seen_rsp;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 7'd0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;

        // Reset values after release.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
        check_val("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        check_val("rst_fpu_data1",  fpu_data1,           32'd0);
        check_val("rst_fpu_data2",  fpu_data2,           32'd0);
        check_val("rst_fpu_opcode", {25'd0, fpu_opcode}, 32'd0);
        check_val("rst_rsp_result", rsp_result,          32'd0);
        check_val("rst_rsp_tag",    {28'd0, rsp_tag},    32'd0);
        check_val("rst_rsp_err",    {31'd0, rsp_err},    32'd0);
        check_val("rst_op_count",   {16'd0, op_count},   32'd0);

        // Reset pulsed asynchronously while the command is in WAIT.
        cmd_valid = 1'b1;
        cmd_op    = 7'd1;
        cmd_a     = 32'h3FC00000;
        cmd_b     = 32'h40100000;
        cmd_tag   = 4'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_val("abort_in_wait",   {31'd0, cmd_ready},  32'd0);
        check_val("abort_opcode_in", {25'd0, fpu_opcode}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("abort_fpu_data1", fpu_data1,           32'd0);
        check_val("abort_fpu_op",    {25'd0, fpu_opcode}, 32'd0);
        check_val("abort_rsp_tag",   {28'd0, rsp_tag},    32'd0);
        check_val("abort_rsp_valid", {31'd0, rsp_valid},  32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_val("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        seen_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen_rsp = 1'b1;
            @(posedge clk); #1;
        end
        check_val("abort_no_rsp", {31'd0, seen_rsp}, 32'd0);

        // Add, FPU_LAT=2.
        issue(7'd1, 32'h3FC00000, 32'h40100000, 4'd5, lat);
        check_val("add_latency",   32'(lat),          32'd3);
        check_val("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_val("add_result",    rsp_result,         32'h40700000);
        check_val("add_tag",       {28'd0, rsp_tag},   32'd5);
        check_val("add_err",       {31'd0, rsp_err},   32'd0);
        finish_rsp();
        check_val("add_op_count",  {16'd0, op_count},  32'd1);

        // Sub with four stalled response cycles.
        issue(7'd2, 32'h40700000, 32'h3FC00000, 4'd6, lat);
        check_val("sub_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 4; i++) begin
            check_val("sub_stall_result", rsp_result,          32'h40100000);
            check_val("sub_stall_ready",  {31'd0, cmd_ready},  32'd0);
            check_val("sub_stall_valid",  {31'd0, rsp_valid},  32'd1);
            @(posedge clk); #1;
        end
        check_val("sub_fpu_data2", fpu_data2,        32'h3FC00000);
        check_val("sub_tag",       {28'd0, rsp_tag}, 32'd6);

        // Mul presented during the sub handshake: must not be taken in that cycle.
        cmd_valid = 1'b1;
        cmd_op    = 7'd3;
        cmd_a     = 32'h40000000;
        cmd_b     = 32'h40400000;
        cmd_tag   = 4'd7;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val("b2b_no_accept_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("b2b_rsp_dropped",     {31'd0, rsp_valid}, 32'd0);
        check_val("sub_op_count",        {16'd0, op_count},  32'd2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_val("mul_accepted", {31'd0, cmd_ready},  32'd0);
        check_val("mul_opcode",   {25'd0, fpu_opcode}, 32'd3);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("mul_latency", 32'(lat),         32'd3);
        check_val("mul_result",  rsp_result,       32'h40C00000);
        check_val("mul_tag",     {28'd0, rsp_tag}, 32'd7);
        finish_rsp();
        check_val("mul_op_count", {16'd0, op_count}, 32'd3);

        // Illegal opcode.
        issue(7'h07, 32'h12345678, 32'h9ABCDEF0, 4'd9, lat);
        check_val("ill_latency",   32'(lat),            32'd1);
        check_val("ill_err",       {31'd0, rsp_err},    32'd1);
        check_val("ill_result",    rsp_result,          32'd0);
        check_val("ill_tag",       {28'd0, rsp_tag},    32'd9);
        check_val("ill_fpu_data1", fpu_data1,           32'h40000000);
        check_val("ill_fpu_data2", fpu_data2,           32'h40400000);
        check_val("ill_fpu_op",    {25'd0, fpu_opcode}, 32'd3);
        finish_rsp();
        check_val("ill_op_count",  {16'd0, op_count},   32'd3);
        check_val("ill_cmd_ready", {31'd0, cmd_ready},  32'd1);

        // Saturation: preload the counter, then complete three legal ops.
        force dut.op_count_r = 16'hFFFE;
        #1;
        release dut.op_count_r;
        #1;
        issue(7'd1, 32'h3FC00000, 32'h40100000, 4'd1, lat);
        check_val("sat1_result", rsp_result, 32'h40700000);
        finish_rsp();
        check_val("sat1_op_count", {16'd0, op_count}, 32'h0000FFFF);
        issue(7'd1, 32'h3FC00000, 32'h40100000, 4'd2, lat);
        finish_rsp();
        issue(7'd1, 32'h3FC00000, 32'h40100000, 4'd3, lat);
        check_val("sat3_tag", {28'd0, rsp_tag}, 32'd3);
        finish_rsp();
        check_val("sat3_op_count", {16'd0, op_count}, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
